// File: rtl/lrf_window_feeder.sv
// Sliding-window frame feeder: stores the last WINDOW_SIZE+1 frames in a ring
// buffer and emits each new frame followed by the frame WINDOW_SIZE earlier.
//   state  | meaning
//   ST_NEW | accept input beats, store them and forward them downstream
//   ST_OLD | input stalled, replay the old frame from the ring buffer
module lrf_window_feeder #(
    parameter int PIXELS_PER_BEAT = 16,
    parameter int PIXEL_WIDTH     = 8,
    parameter int IMAGE_DIM       = 64,
    parameter int N_FUSE_COUNT    = 4
) (
    input  logic                                   s_axis_aclk,
    input  logic                                   s_axis_aresetn,
    input  logic [PIXEL_WIDTH*PIXELS_PER_BEAT-1:0] s_axis_tdata,
    input  logic                                   s_axis_tvalid,
    output logic                                   s_axis_tready,
    input  logic                                   s_axis_tlast,
    output logic [PIXEL_WIDTH*PIXELS_PER_BEAT-1:0] m_axis_tdata,
    output logic                                   m_axis_tvalid,
    input  logic                                   m_axis_tready,
    output logic                                   m_axis_tlast,
    output logic                                   frame_err
);
    localparam int WORD_WIDTH  = PIXEL_WIDTH * PIXELS_PER_BEAT;
    localparam int WPI         = IMAGE_DIM * IMAGE_DIM / PIXELS_PER_BEAT;
    localparam int WINDOW_SIZE = 1 << N_FUSE_COUNT;
    localparam int SLOTS       = WINDOW_SIZE + 1;
    localparam int DEPTH       = SLOTS * WPI;
    localparam int ADDR_W      = $clog2(DEPTH);
    localparam int BEAT_W      = (WPI > 1) ? $clog2(WPI) : 1;
    localparam int SLOT_W      = $clog2(SLOTS);
    localparam int SEEN_W      = $clog2(WINDOW_SIZE + 1);

    typedef enum logic {ST_NEW, ST_OLD} state_t;

    state_t                  state_q;
    logic                    run_q;
    logic [BEAT_W-1:0]       beat_q, rd_beat_q;
    logic                    rd_done_q;
    logic [SLOT_W-1:0]       wr_slot_q;
    logic [SEEN_W-1:0]       frames_seen_q;
    logic                    frame_err_q;
    logic                    out_valid_q, out_last_q;
    logic [WORD_WIDTH-1:0]   out_data_q;
    logic                    hold_valid_q, hold_last_q;
    logic [WORD_WIDTH-1:0]   hold_data_q;
    logic                    rd_pend_q, rd_last_q;
    logic [WORD_WIDTH-1:0]   rd_data_q;
    logic [WORD_WIDTH-1:0]   mem_q [DEPTH];

    logic                    m_fire, out_free, s_fire, beat_last, rd_last, rd_issue;
    logic [1:0]              in_flight;
    logic [SLOT_W-1:0]       old_slot;
    logic [ADDR_W-1:0]       wr_addr, rd_addr;

    assign m_fire        = out_valid_q && m_axis_tready;
    assign out_free      = !out_valid_q || m_axis_tready;
    assign s_axis_tready = run_q && (state_q == ST_NEW) && out_free;
    assign s_fire        = s_axis_tvalid && s_axis_tready;
    assign beat_last     = (beat_q == BEAT_W'(WPI - 1));
    assign rd_last       = (rd_beat_q == BEAT_W'(WPI - 1));

    // Words owned by the output side: output reg, holding reg, read in flight.
    // A read may only issue when both registers can absorb it after this cycle.
    assign in_flight = {1'b0, out_valid_q} + {1'b0, hold_valid_q} + {1'b0, rd_pend_q};
    assign rd_issue  = (state_q == ST_OLD) && !rd_done_q
                       && ((in_flight - {1'b0, m_fire}) <= 2'd1);

    always_comb begin
        old_slot = '0;
        if (frames_seen_q == SEEN_W'(WINDOW_SIZE))
            old_slot = (wr_slot_q == SLOT_W'(SLOTS - 1)) ? '0 : wr_slot_q + SLOT_W'(1);
    end

    assign wr_addr = ADDR_W'(wr_slot_q) * ADDR_W'(WPI) + ADDR_W'(beat_q);
    assign rd_addr = ADDR_W'(old_slot) * ADDR_W'(WPI) + ADDR_W'(rd_beat_q);

    always_ff @(posedge s_axis_aclk) begin
        if (s_fire)
            mem_q[wr_addr] <= s_axis_tdata;
        if (rd_issue)
            rd_data_q <= mem_q[rd_addr];
    end

    always_ff @(posedge s_axis_aclk or negedge s_axis_aresetn) begin
        if (!s_axis_aresetn) begin
            state_q       <= ST_NEW;
            run_q         <= 1'b0;
            beat_q        <= '0;
            rd_beat_q     <= '0;
            rd_done_q     <= 1'b0;
            wr_slot_q     <= '0;
            frames_seen_q <= '0;
            frame_err_q   <= 1'b0;
            out_valid_q   <= 1'b0;
            out_last_q    <= 1'b0;
            out_data_q    <= '0;
            hold_valid_q  <= 1'b0;
            hold_last_q   <= 1'b0;
            hold_data_q   <= '0;
            rd_pend_q     <= 1'b0;
            rd_last_q     <= 1'b0;
        end else begin
            run_q     <= 1'b1;
            rd_pend_q <= rd_issue;
            if (rd_issue) begin
                rd_last_q <= rd_last;
                if (rd_last) begin
                    rd_beat_q <= '0;
                    rd_done_q <= 1'b1;
                end else begin
                    rd_beat_q <= rd_beat_q + 1'b1;
                end
            end

            if (state_q == ST_NEW) begin
                if (s_fire) begin
                    out_valid_q <= 1'b1;
                    out_data_q  <= s_axis_tdata;
                    out_last_q  <= beat_last;
                    if (s_axis_tlast != beat_last)
                        frame_err_q <= 1'b1;
                    if (beat_last) begin
                        beat_q  <= '0;
                        state_q <= ST_OLD;
                    end else begin
                        beat_q <= beat_q + 1'b1;
                    end
                end else if (m_fire) begin
                    out_valid_q <= 1'b0;
                end
            end else begin
                if (out_free) begin
                    if (hold_valid_q) begin
                        out_valid_q  <= 1'b1;
                        out_data_q   <= hold_data_q;
                        out_last_q   <= hold_last_q;
                        hold_valid_q <= rd_pend_q;
                        hold_data_q  <= rd_data_q;
                        hold_last_q  <= rd_last_q;
                    end else if (rd_pend_q) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= rd_data_q;
                        out_last_q  <= rd_last_q;
                    end else begin
                        out_valid_q <= 1'b0;
                    end
                end else if (rd_pend_q) begin
                    hold_valid_q <= 1'b1;
                    hold_data_q  <= rd_data_q;
                    hold_last_q  <= rd_last_q;
                end

                // rd_done_q separates the final OLD word from the NEW tail word.
                if (m_fire && out_last_q && rd_done_q) begin
                    state_q   <= ST_NEW;
                    rd_done_q <= 1'b0;
                    rd_beat_q <= '0;
                    wr_slot_q <= (wr_slot_q == SLOT_W'(SLOTS - 1)) ? '0 : wr_slot_q + SLOT_W'(1);
                    if (frames_seen_q != SEEN_W'(WINDOW_SIZE))
                        frames_seen_q <= frames_seen_q + 1'b1;
                end
            end
        end
    end

    assign m_axis_tvalid = out_valid_q;
    assign m_axis_tlast  = out_last_q;
    assign m_axis_tdata  = out_data_q;
    assign frame_err     = frame_err_q;

endmodule

// File: tb/tb_lrf_window_feeder.sv
// Scoreboard bench for lrf_window_feeder: warm-up, wrap, framing error,
// mid-frame reset and random back-pressure, all against a frame-history model.
module tb_lrf_window_feeder;
    localparam int WW  = 128;
    localparam int WPI = 256;
    localparam int WIN = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b1;
    logic [WW-1:0] s_tdata = '0;
    logic          s_tvalid = 1'b0;
    logic          s_tlast = 1'b0;
    logic          s_tready;
    logic [WW-1:0] m_tdata;
    logic          m_tvalid;
    logic          m_tready = 1'b0;
    logic          m_tlast;
    logic          frame_err;

    int            compared = 0;
    int            mismatched = 0;
    logic [WW:0]   exp_q[$];
    int            hist[$];
    bit            rnd_ready = 1'b0;
    int            cyc = 0;
    int            last_first = -1;

    logic          prev_hs = 1'b0, prev_stall = 1'b0, prev_ml = 1'b0;
    logic [WW-1:0] prev_sd = '0, prev_md = '0;
    logic [WW:0]   exp_word;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    lrf_window_feeder dut (
        .s_axis_aclk    (clk),
        .s_axis_aresetn (rst_n),
        .s_axis_tdata   (s_tdata),
        .s_axis_tvalid  (s_tvalid),
        .s_axis_tready  (s_tready),
        .s_axis_tlast   (s_tlast),
        .m_axis_tdata   (m_tdata),
        .m_axis_tvalid  (m_tvalid),
        .m_axis_tready  (m_tready),
        .m_axis_tlast   (m_tlast),
        .frame_err      (frame_err)
    );

    task automatic check(input string tag, input logic [WW+1:0] obs, input logic [WW+1:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // code[16] selects constant-byte frames; otherwise pixel0=beat, pixel1=tag, rest a ramp.
    function automatic logic [WW-1:0] word(input int code, input int beat);
        logic [WW-1:0] w;
        for (int p = 0; p < 16; p++)
            w[p*8 +: 8] = code[16] ? 8'(code) : 8'(code * 37 + beat * 16 + p);
        if (!code[16]) begin
            w[7:0]  = 8'(beat);
            w[15:8] = 8'(code);
        end
        return w;
    endfunction

    task automatic stop_on_timeout(input string tag);
        compared++;
        mismatched++;
        $display("FAIL %s observed=no progress expected=progress within bound", tag);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $fatal(1, "bench stopped after %s", tag);
    endtask

    task automatic do_reset();
        s_tvalid = 1'b0;
        rst_n    = 1'b0;
        exp_q.delete();
        hist.delete();
        last_first = -1;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", {m_tvalid, m_tlast, s_tready, frame_err}, '0);
        check("reset_data", m_tdata, '0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("tready_rise", s_tready, 1);
    endtask

    task automatic send_frame(input int code, input bit rnd, input int err_beat, input int rst_beat);
        int n;
        int old;
        int waitc;
        bit acc;
        n = hist.size();
        hist.push_back(code);
        old = (n >= WIN) ? hist[n-WIN] : hist[0];
        for (int b = 0; b < WPI; b++) exp_q.push_back({(b == WPI-1), word(code, b)});
        for (int b = 0; b < WPI; b++) exp_q.push_back({(b == WPI-1), word(old, b)});
        for (int b = 0; b < WPI; b++) begin
            s_tdata = word(code, b);
            s_tlast = (b == WPI-1) != (b == err_beat);
            if (b == rst_beat) begin
                s_tvalid = 1'b1;
                #2 rst_n = 1'b0;
                #1;
                check("async_reset_flags", {m_tvalid, m_tlast, s_tready, frame_err}, '0);
                check("async_reset_data", m_tdata, '0);
                s_tvalid = 1'b0;
                exp_q.delete();
                hist.delete();
                return;
            end
            acc   = 1'b0;
            waitc = 0;
            while (!acc) begin
                s_tvalid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
                @(negedge clk);
                acc = s_tvalid && s_tready;
                @(posedge clk);
                #1;
                waitc++;
                if (waitc > 5000) stop_on_timeout("accept_timeout");
            end
            if (b == 0) begin
                if (!rnd && last_first >= 0)
                    check("pair_cycles_le_2wpi_plus_2", {130'(cyc - last_first <= 2*WPI + 2)}, 1);
                last_first = rnd ? -1 : cyc;
            end
            if (b == err_beat) check("frame_err_set", frame_err, 1);
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
    endtask

    task automatic wait_drain();
        int waitc;
        waitc = 0;
        while (exp_q.size() != 0) begin
            @(posedge clk);
            #1;
            waitc++;
            if (waitc > 20000) stop_on_timeout("drain_timeout");
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        m_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_hs    <= 1'b0;
            prev_stall <= 1'b0;
        end else begin
            if (prev_hs)
                check("new_latency", {1'b0, m_tvalid, m_tdata}, {2'b01, prev_sd});
            if (prev_stall)
                check("stall_stable", {m_tvalid, m_tlast, m_tdata}, {1'b1, prev_ml, prev_md});
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    check("extra_word", {1'b1, m_tlast, m_tdata}, '0);
                end else begin
                    exp_word = exp_q.pop_front();
                    check("out_word", {1'b0, m_tlast, m_tdata}, {1'b0, exp_word});
                end
            end
            prev_hs    <= s_tvalid && s_tready;
            prev_sd    <= s_tdata;
            prev_stall <= m_tvalid && !m_tready;
            prev_md    <= m_tdata;
            prev_ml    <= m_tlast;
        end
    end

    initial begin
        #1 rst_n = 1'b0;
        #1;
        check("por_flags", {m_tvalid, m_tlast, s_tready, frame_err}, '0);
        check("por_data", m_tdata, '0);
        do_reset();

        // warm-up and steady state with slot wrap, constant-byte frames
        for (int i = 0; i < 41; i++) send_frame(i | 32'h10000, 1'b0, -1, -1);
        wait_drain();
        check("frame_err_clean", frame_err, 0);

        // framing error in frame 3, then reset during beat 120 of frame 20
        do_reset();
        for (int i = 0; i < 20; i++) begin
            send_frame(i + 100, 1'b0, (i == 3) ? 100 : -1, -1);
            if (i == 2) check("frame_err_before", frame_err, 0);
        end
        check("frame_err_sticky", frame_err, 1);
        send_frame(120, 1'b0, -1, 120);
        do_reset();
        check("frame_err_after_reset", frame_err, 0);
        send_frame(77, 1'b0, -1, -1);
        wait_drain();

        // random back-pressure on both sides
        do_reset();
        rnd_ready = 1'b1;
        for (int i = 0; i < 20; i++) send_frame(i + 50, 1'b1, -1, -1);
        wait_drain();
        rnd_ready = 1'b0;
        check("queue_empty_end", exp_q.size(), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
